// File: rtl/madd_eval_pkg.sv
// rtl/madd_eval_pkg.sv - shared widths, FSM state type and helpers for the multiply-add error evaluator
package madd_eval_pkg;
    localparam int VEC_W   = 6;
    localparam int RES_W   = 4;
    localparam int CNT_W   = 7;
    localparam int SUM_W   = 10;
    localparam int SQ_W    = 14;
    localparam int NUM_VEC = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [RES_W-1:0] abs_diff(input logic [RES_W-1:0] x, input logic [RES_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction
endpackage

// File: rtl/madd_exact_ref.sv
// rtl/madd_exact_ref.sv - combinational exact a*b+c reference for one 6-bit input vector
module madd_exact_ref
    import madd_eval_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic [RES_W-1:0] exact_o
);
    logic [RES_W-1:0] a, b, c;

    assign a = {2'b00, vec_i[1:0]};
    assign b = {2'b00, vec_i[3:2]};
    assign c = {2'b00, vec_i[5:4]};
    assign exact_o = a * b + c;
endmodule

// File: rtl/madd_err_eval.sv
// rtl/madd_err_eval.sv - exhaustive sweep and error metrics for a 2x2-bit multiply-add circuit
// Optional squared-error accumulator: MADD_EVAL_MSE_EN
module madd_err_eval
    import madd_eval_pkg::*;
#(
    parameter int DUT_LATENCY = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [VEC_W-1:0] dut_in_o,
    input  logic [RES_W-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [SUM_W-1:0] sum_abs_err_o,
    output logic [RES_W-1:0] max_abs_err_o,
    output logic [VEC_W-1:0] max_err_vec_o
`ifdef MADD_EVAL_MSE_EN
    ,
    output logic [SQ_W-1:0]  sum_sq_err_o
`endif
);
    localparam logic [2:0] DRAIN_LAST = 3'(DUT_LATENCY - 1);

    state_e           state_q;
    logic [VEC_W-1:0] vec_q;
    logic [2:0]       drain_q;
    logic             busy_q, done_q;
    logic             start_ok;

    assign start_ok = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                        if (DUT_LATENCY > 0) begin
                            state_q <= ST_DRAIN;
                            drain_q <= '0;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        vec_q <= vec_q + VEC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dut_in_o = vec_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

    logic [RES_W-1:0] cur_exact;
    logic             cur_valid;
    logic             tap_valid;
    logic [RES_W-1:0] tap_exact;
    logic [VEC_W-1:0] tap_idx;

    madd_exact_ref u_exact_ref (
        .vec_i   (vec_q),
        .exact_o (cur_exact)
    );

    assign cur_valid = (state_q == ST_RUN);

    // Delay the reference and index so they meet the circuit's result in the same cycle.
    generate
        if (DUT_LATENCY == 0) begin : g_comb
            assign tap_valid = cur_valid;
            assign tap_exact = cur_exact;
            assign tap_idx   = vec_q;
        end else begin : g_pipe
            logic [DUT_LATENCY-1:0] vld_q;
            logic [RES_W-1:0]       ex_q  [DUT_LATENCY];
            logic [VEC_W-1:0]       idx_q [DUT_LATENCY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int i = 0; i < DUT_LATENCY; i++) begin
                        ex_q[i]  <= '0;
                        idx_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= cur_valid;
                    ex_q[0]  <= cur_exact;
                    idx_q[0] <= vec_q;
                    for (int i = 1; i < DUT_LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        ex_q[i]  <= ex_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign tap_valid = vld_q[DUT_LATENCY-1];
            assign tap_exact = ex_q[DUT_LATENCY-1];
            assign tap_idx   = idx_q[DUT_LATENCY-1];
        end
    endgenerate

    logic [RES_W-1:0] abs_err;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [RES_W-1:0] max_q, max_d;
    logic [VEC_W-1:0] mvec_q, mvec_d;

    assign abs_err = abs_diff(dut_out_i, tap_exact);

    always_comb begin
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        max_d  = max_q;
        mvec_d = mvec_q;
        if (start_ok) begin
            cnt_d  = '0;
            sum_d  = '0;
            max_d  = '0;
            mvec_d = '0;
        end else if (tap_valid) begin
            cnt_d = cnt_q + CNT_W'(abs_err != '0);
            sum_d = sum_q + SUM_W'(abs_err);
            // Strictly greater keeps the lowest-index worst vector.
            if (abs_err > max_q) begin
                max_d  = abs_err;
                mvec_d = tap_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            mvec_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            max_q  <= max_d;
            mvec_q <= mvec_d;
        end
    end

    assign err_count_o   = cnt_q;
    assign sum_abs_err_o = sum_q;
    assign max_abs_err_o = max_q;
    assign max_err_vec_o = mvec_q;

`ifdef MADD_EVAL_MSE_EN
    logic [2*RES_W-1:0] sq_err;
    logic [SQ_W-1:0]    sq_q, sq_d;

    assign sq_err = {{RES_W{1'b0}}, abs_err} * {{RES_W{1'b0}}, abs_err};

    always_comb begin
        sq_d = sq_q;
        if (start_ok) begin
            sq_d = '0;
        end else if (tap_valid) begin
            sq_d = sq_q + SQ_W'(sq_err);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sum_sq_err_o = sq_q;
`endif
endmodule

// File: tb/tb_madd_err_eval.sv
// tb/tb_madd_err_eval.sv - randomized self-checking bench for madd_err_eval at latency 0 and 2
module tb_madd_err_eval;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start;
    int           mode;
    logic [255:0] lut;

    logic [5:0] din0, din2, vec0, vec2;
    logic [3:0] dout0, dout2, s1, s2, max0, max2;
    logic       busy0, busy2, done0, done2;
    logic [6:0] cnt0, cnt2;
    logic [9:0] sum0, sum2;
`ifdef MADD_EVAL_MSE_EN
    logic [13:0] sq0, sq2;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt, exp_sum, exp_max, exp_vec, exp_sq;

    // Circuit under evaluation: 0 exact, 1 stuck at 0, 2 exact+1, 3 random table
    function automatic logic [3:0] circ(input int m, input logic [5:0] v, input logic [255:0] tbl);
        int iv, e;
        iv = int'(v);
        e  = (iv % 4) * ((iv / 4) % 4) + iv / 16;
        case (m)
            0:       return 4'(e);
            1:       return 4'd0;
            2:       return 4'(e + 1);
            default: return tbl[iv*4 +: 4];
        endcase
    endfunction

    always_comb dout0 = circ(mode, din0, lut);
    always @(posedge clk) begin
        s1 <= circ(mode, din2, lut);
        s2 <= s1;
    end
    assign dout2 = s2;

    madd_err_eval #(.DUT_LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .dut_in_o(din0), .dut_out_i(dout0),
        .busy_o(busy0), .done_o(done0), .err_count_o(cnt0), .sum_abs_err_o(sum0),
        .max_abs_err_o(max0), .max_err_vec_o(vec0)
`ifdef MADD_EVAL_MSE_EN
        , .sum_sq_err_o(sq0)
`endif
    );

    madd_err_eval #(.DUT_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .dut_in_o(din2), .dut_out_i(dout2),
        .busy_o(busy2), .done_o(done2), .err_count_o(cnt2), .sum_abs_err_o(sum2),
        .max_abs_err_o(max2), .max_err_vec_o(vec2)
`ifdef MADD_EVAL_MSE_EN
        , .sum_sq_err_o(sq2)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model();
        int e, o, d;
        exp_cnt = 0; exp_sum = 0; exp_max = 0; exp_vec = 0; exp_sq = 0;
        for (int v = 0; v < 64; v++) begin
            e = (v % 4) * ((v / 4) % 4) + v / 16;
            o = int'(circ(mode, 6'(v), lut));
            d = (o > e) ? o - e : e - o;
            if (d != 0) exp_cnt++;
            exp_sum += d;
            exp_sq  += d * d;
            if (d > exp_max) begin
                exp_max = d;
                exp_vec = v;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt0"}, int'(cnt0), 0);
        check({tag, "_sum0"}, int'(sum0), 0);
        check({tag, "_max0"}, int'(max0), 0);
        check({tag, "_vec0"}, int'(vec0), 0);
        check({tag, "_cnt2"}, int'(cnt2), 0);
        check({tag, "_sum2"}, int'(sum2), 0);
        check({tag, "_max2"}, int'(max2), 0);
        check({tag, "_vec2"}, int'(vec2), 0);
`ifdef MADD_EVAL_MSE_EN
        check({tag, "_sq0"}, int'(sq0), 0);
        check({tag, "_sq2"}, int'(sq2), 0);
`endif
    endtask

    task automatic check_results(input string tag);
        model();
        check({tag, "_cnt0"}, int'(cnt0), exp_cnt);
        check({tag, "_sum0"}, int'(sum0), exp_sum);
        check({tag, "_max0"}, int'(max0), exp_max);
        check({tag, "_vec0"}, int'(vec0), exp_vec);
        check({tag, "_cnt2"}, int'(cnt2), exp_cnt);
        check({tag, "_sum2"}, int'(sum2), exp_sum);
        check({tag, "_max2"}, int'(max2), exp_max);
        check({tag, "_vec2"}, int'(vec2), exp_vec);
`ifdef MADD_EVAL_MSE_EN
        check({tag, "_sq0"}, int'(sq0), exp_sq);
        check({tag, "_sq2"}, int'(sq2), exp_sq);
`endif
    endtask

    // Cycle k counts edges after the one that samples start.
    task automatic run_sweep(input string tag, input int pulse_at, input int abort_at);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 1) check_zero({tag, "_clr"});
            if (k == abort_at) begin
                check({tag, "_din_pre_rst"}, int'(din0), k - 1);
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, int'(busy0) + int'(busy2), 0);
                check({tag, "_rst_done"}, int'(done0) + int'(done2), 0);
                check({tag, "_rst_din"}, int'(din0) + int'(din2), 0);
                check_zero({tag, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check($sformatf("%s_busy0_c%0d", tag, k), int'(busy0), int'(k <= 64));
            check($sformatf("%s_done0_c%0d", tag, k), int'(done0), int'(k >= 65));
            check($sformatf("%s_busy2_c%0d", tag, k), int'(busy2), int'(k <= 66));
            check($sformatf("%s_done2_c%0d", tag, k), int'(done2), int'(k >= 67));
            check($sformatf("%s_din0_c%0d", tag, k), int'(din0), (k <= 64) ? k - 1 : 63);
            check($sformatf("%s_din2_c%0d", tag, k), int'(din2), (k <= 64) ? k - 1 : 63);
            start = (k == pulse_at);
        end
        start = 1'b0;
        check_results(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        lut   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy0) + int'(busy2), 0);
        check("reset_done", int'(done0) + int'(done2), 0);
        check("reset_din", int'(din0) + int'(din2), 0);
        check_zero("reset");
        rst_n = 1'b1;

        mode = 0;
        run_sweep("exact", 0, 0);

        mode = 1;
        run_sweep("stuck_pulse", 30, 0);
        check("stuck_cnt_const", int'(cnt0), 57);
        check("stuck_sum_const", int'(sum0), 240);
        check("stuck_max_const", int'(max0), 12);
        check("stuck_vec_const", int'(vec0), 63);
`ifdef MADD_EVAL_MSE_EN
        check("stuck_sq_const", int'(sq0), 1440);
`endif
        run_sweep("stuck_restart", 0, 0);

        mode = 2;
        run_sweep("plus1", 0, 0);
        check("plus1_cnt_const", int'(cnt0), 64);
        check("plus1_max_vec_const", int'(vec0), 0);

        for (int r = 0; r < 4; r++) begin
            mode = 3;
            lut  = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            run_sweep($sformatf("rand%0d", r), (r == 1) ? int'($urandom_range(2, 60)) : 0, 0);
        end

        mode = 1;
        run_sweep("abort", 0, 21);
        mode = 3;
        lut  = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        run_sweep("after_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/madd_err_eval.md
# madd_err_eval

Sequential exhaustive error evaluator for 2×2-bit multiply-add circuits (`a*b + c`, 6 inputs, 4 outputs). It sits around the circuit under evaluation:

- Upstream, it drives every 6-bit input vector into the circuit.
- Downstream, it captures the circuit's 4-bit result, compares it against the exact arithmetic value and accumulates error metrics.

Results are presented with a start/done handshake for the approximate-circuit error-evaluation flow.

## Interface
- `DUT_LATENCY`, default 0: register stages between `dut_in` and a valid `dut_out` (0 = combinational circuit); legal range 0–4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `dut_in` out 6: stimulus to the circuit; bits [1:0]=a, [3:2]=b, [5:4]=c.
- `dut_out` in 4: circuit result.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE; results valid and stable.
- `err_count` out 7: vectors with `dut_out` ≠ exact (0–64).
- `sum_abs_err` out 10: Σ|dut_out − exact| (max 960).
- `max_abs_err` out 4: largest single absolute error.
- `max_err_vec` out 6: lowest vector index achieving `max_abs_err` (0 if no error).

## Operation
- Exact value = a*b + c, computed at 4 bits (range 0–12). abs_err = |dut_out − exact|, 4 bits, unsigned compare.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + `start` → RUN. On this transition, clear all accumulators and zero the vector counter.
  - RUN: `dut_in` = counter, and the counter increments every cycle. After vector 63 is driven → DRAIN if `DUT_LATENCY` > 0, else → DONE.
  - DRAIN: lasts exactly `DUT_LATENCY` cycles → DONE. `dut_in` holds 63.
- Alignment:
  - The exact value and the vector index are delayed through a `DUT_LATENCY`-deep valid/data shift line.
  - `dut_out` is sampled only when the delayed valid bit is high.
  - Exactly 64 comparisons occur per sweep.
- Max tracking: update only on strictly greater error, so the first (lowest-index) worst vector wins.
- `start` while busy is ignored. `start` in DONE restarts the sweep, and results are cleared on the restart edge.
- Outputs hold their values in DONE until the next `start`.

## Timing
- Reset: state=IDLE; `dut_in`=0, `busy`=0, `done`=0; all metrics 0; shift line cleared. Reset takes effect immediately, including mid-sweep, and the block resumes in IDLE.
- Cycle 0: `start` is sampled. Cycles 1–64: RUN with `dut_in` = 0…63, `busy`=1.
- Cycles 65 to 64+`DUT_LATENCY`: DRAIN.
- Cycle 65+`DUT_LATENCY`: `done`=1, `busy`=0; metrics include all 64 vectors.
- Accumulators are registered. The metric for the vector whose result arrives at cycle t is visible at cycle t+1.
- `done` and `busy` are never high together.

## Configuration
- `MADD_EVAL_MSE_EN` defined:
  - Adds output `sum_sq_err` (14 bits), Σ abs_err² (max 14400).
  - It is cleared and updated under the same rules as `sum_abs_err`.
- `MADD_EVAL_MSE_EN` undefined: the port, the squarer and the accumulator are absent. All other behaviour is identical.

## Structure
- Package `madd_eval_pkg` contains:
  - state enum
  - width constants: `VEC_W`=6, `RES_W`=4, `CNT_W`=7, `SUM_W`=10, `SQ_W`=14
  - `NUM_VEC`=64
- Sub-module `madd_exact_ref`: combinational 6→4 exact a*b+c reference, instantiated once on the `dut_in` side ahead of the delay line.

## Test plan
- Bench DUT = exact model, `DUT_LATENCY`=0, one sweep → `err_count`=0, `sum_abs_err`=0, `max_abs_err`=0, `max_err_vec`=0; `done` at cycle 65.
- Bench DUT stuck at 0 → `err_count`=57, `sum_abs_err`=240, `max_abs_err`=12, `max_err_vec`=63; with `MADD_EVAL_MSE_EN`, `sum_sq_err`=1440.
- Bench DUT = exact+1 → `err_count`=64, `sum_abs_err`=64, `max_abs_err`=1, `max_err_vec`=0.
- `DUT_LATENCY`=2 with a 2-stage registered exact model → all metrics 0; `done` first high at cycle 67; `busy` high cycles 1–66.
- `start` pulsed at cycle 30 of RUN → ignored, `done` still at cycle 65. A second `start` in DONE → metrics clear next cycle and the sweep repeats with identical results.
- `rst_n` low while `dut_in`=20 → immediate IDLE, all outputs 0. A following `start` gives full, correct 64-vector results.
